// File: rtl/counters_controller.sv
// Free-running four-digit BCD counter that wraps from a parameterised terminal
// count back to 0000, with per-digit strobes that flag an imminent return to zero.
`timescale 1ns/1ps

module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);
    logic [3:0] q_q;
    logic [3:0] q_d;

    // clr wins over inc so the terminal wrap clears every digit in one edge.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == 4'd9);
endmodule

module counters_controller #(
    parameter int unsigned LIM_THOU  = 9,
    parameter int unsigned LIM_HUND  = 6,
    parameter int unsigned LIM_TENS  = 7,
    parameter int unsigned LIM_UNITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    output logic [15:0] Qdata,
    output logic [3:0]  blink
);
    localparam logic [15:0] TERM_VAL = {4'(LIM_THOU), 4'(LIM_HUND), 4'(LIM_TENS), 4'(LIM_UNITS)};

    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hund;
    logic [3:0] thou;
    logic       units_carry;
    logic       tens_carry;
    logic       hund_carry;
    logic       thou_carry;
    logic       term;
    logic       units_inc;
    logic       clr_all;
    logic       active;

    assign Qdata     = {thou, hund, tens, units};
    assign term      = (Qdata == TERM_VAL);
    assign units_inc = ena & ~term;
    assign clr_all   = ena & term;
    assign active    = ena & ~reset;

    bcd_digit u_units (
        .clk   (clk),
        .reset (reset),
        .inc   (units_inc),
        .clr   (clr_all),
        .q     (units),
        .carry (units_carry)
    );

    bcd_digit u_tens (
        .clk   (clk),
        .reset (reset),
        .inc   (units_carry),
        .clr   (clr_all),
        .q     (tens),
        .carry (tens_carry)
    );

    bcd_digit u_hund (
        .clk   (clk),
        .reset (reset),
        .inc   (tens_carry),
        .clr   (clr_all),
        .q     (hund),
        .carry (hund_carry)
    );

    // The thousands carry-out is unused: the terminal clear always fires first.
    bcd_digit u_thou (
        .clk   (clk),
        .reset (reset),
        .inc   (hund_carry),
        .clr   (clr_all),
        .q     (thou),
        .carry (thou_carry)
    );

    always_comb begin
        blink    = 4'b0000;
        blink[0] = active & ((units == 4'd9) | term);
        blink[1] = active & (((units == 4'd9) & (tens == 4'd9)) | term);
        blink[2] = active & (((units == 4'd9) & (tens == 4'd9) & (hund == 4'd9)) | term);
        blink[3] = active & term;
    end

    logic unused_carry;
    assign unused_carry = thou_carry;
endmodule

// File: tb/tb_counters_controller.sv
// Randomised and directed bench for counters_controller, checked every cycle
// against a decimal-integer model of the counter.
`timescale 1ns/1ps

module tb_counters_controller;
    localparam int TERM = 9675;

    logic        clk;
    logic        reset;
    logic        ena;
    logic [15:0] Qdata;
    logic [3:0]  blink;

    int n_checks = 0;
    int n_fail   = 0;
    int model_n  = 0;

    counters_controller #(
        .LIM_THOU  (9),
        .LIM_HUND  (6),
        .LIM_TENS  (7),
        .LIM_UNITS (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .Qdata (Qdata),
        .blink (blink)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Digit i returns to zero on the next edge when n+1 is a multiple of 10^(i+1),
    // or when the whole count wraps from the terminal value.
    function automatic logic [3:0] exp_blink(input int n, input logic r, input logic e);
        int p;
        logic [3:0] b;
        b = 4'b0000;
        p = 10;
        for (int i = 0; i < 4; i++) begin
            b[i] = e & ~r & ((n == TERM) | ((i < 3) && ((n + 1) % p == 0)));
            p = p * 10;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) model_n = 0;
        else if (ena) model_n = (model_n == TERM) ? 0 : model_n + 1;
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [15:0] eq;
        logic [3:0]  eb;
        eq = to_bcd(model_n);
        eb = exp_blink(model_n, reset, ena);
        n_checks++;
        if (Qdata !== eq) begin
            n_fail++;
            $display("FAIL qdata_cycle t=%0t got=%h exp=%h", $time, Qdata, eq);
        end
        n_checks++;
        if (blink !== eb) begin
            n_fail++;
            $display("FAIL blink_cycle t=%0t got=%b exp=%b (count %h)", $time, blink, eb, eq);
        end
        n_checks++;
        if ((Qdata[3:0] > 4'd9) || (Qdata[7:4] > 4'd9) || (Qdata[11:8] > 4'd9) ||
            (Qdata[15:12] > 4'd9) || (Qdata > 16'h9675)) begin
            n_fail++;
            $display("FAIL bcd_range t=%0t got=%h exp=<=9675 with BCD digits", $time, Qdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic r, input logic e);
        reset = r;
        ena   = e;
        @(posedge clk);
        #0.2;
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic peek_blink(input string name, input logic r, input logic e, input logic [3:0] exp);
        reset = r;
        ena   = e;
        #0.1;
        check4(name, blink, exp);
    endtask

    task automatic advance_to(input int target);
        int guard;
        guard = 0;
        while (model_n != target && guard < 20000) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        n_checks++;
        if (model_n != target) begin
            n_fail++;
            $display("FAIL advance_to got=%0d exp=%0d", model_n, target);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1;
        ena   = 1'b0;

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        check16("reset_qdata", Qdata, 16'h0000);
        check4("reset_blink", blink, 4'b0000);

        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
        check16("startup_20", Qdata, 16'h0020);

        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1);
        check16("reach_37", Qdata, 16'h0037);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0);
            check16("hold_qdata", Qdata, 16'h0037);
            check4("hold_blink", blink, 4'b0000);
        end

        advance_to(99);
        peek_blink("carry_99_blink", 1'b0, 1'b1, 4'b0011);
        cycle(1'b0, 1'b1);
        check16("carry_100", Qdata, 16'h0100);

        advance_to(999);
        peek_blink("carry_999_blink", 1'b0, 1'b1, 4'b0111);
        cycle(1'b0, 1'b1);
        check16("carry_1000", Qdata, 16'h1000);

        advance_to(TERM);
        check16("reach_term", Qdata, 16'h9675);
        peek_blink("term_blink", 1'b0, 1'b1, 4'b1111);
        cycle(1'b0, 1'b1);
        check16("wrap_0000", Qdata, 16'h0000);
        cycle(1'b0, 1'b1);
        check16("wrap_0001", Qdata, 16'h0001);

        for (int i = 0; i < TERM + 1; i++) cycle(1'b0, 1'b1);
        check16("full_cycle_0001", Qdata, 16'h0001);

        advance_to(4321);
        check16("reach_4321", Qdata, 16'h4321);
        peek_blink("midreset_blink", 1'b1, 1'b1, 4'b0000);
        cycle(1'b1, 1'b1);
        check16("midreset_qdata", Qdata, 16'h0000);
        check4("midreset_blink_hold", blink, 4'b0000);
        cycle(1'b0, 1'b1);
        check16("after_reset_0001", Qdata, 16'h0001);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
        end

        reset = 1'b0;
        ena   = 1'b0;
        @(negedge clk);
        #0.1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
